debug_host_sequencer: RTL and testbench
=======================================

Name: debug_host_sequencer

Overview:
- Upstream command engine for the SystemTest CPU debug port.
- Accepts host commands over a valid/ready handshake: write/read memory, write/read register, run N instructions.
- Converts each command into the exact cycle sequence on SystemTest's test/memoryoperation/registeroperation controls, then returns one response per command.
- Replaces hand-written bench tasks; lets a UART or switch front-end load and run programs on the board.

Parameters:
- MEM_ACC_CYC, 2, cycles memoryoperation is held before MD is sampled.
- REG_ACC_CYC, 2, cycles registeroperation is held before RD is sampled.
- RUN_TIMEOUT, 16'd4096, max execution cycles per RUN before abort.
- FETCH_STATE, 9'd1, state encoding that marks instruction fetch.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block idle, command accepted when valid&ready.
- cmd_op  in  3  0 NOP, 1 WMEM, 2 WREG, 3 RMEM, 4 RREG, 5 RUN, 6-7 illegal.
- cmd_addr  in  16  memory address / register index [3:0] / start PC.
- cmd_data  in  16  write data / RUN instruction count.
- rsp_valid  out  1  one-cycle pulse, response valid.
- rsp_data  out  16  read data, readback, or executed-instruction count.
- rsp_err  out  1  readback mismatch, timeout, or illegal op.
- cpu_reset  out  1  active-high reset into SystemTest.
- test, memoryoperation, registeroperation, memorywrite, registerwrite  out  1 each  SystemTest debug controls.
- memaddress, memwritedata, regwritedata, resetpc  out  16 each  SystemTest debug buses.
- registeraddress  out  4  SystemTest register index.
- MD, RD  in  16  SystemTest memory/register read data.
- state  in  9  SystemTest control state.

Behaviour:
- Reset (reset==0 at posedge): FSM to IDLE. All control outputs 0, all buses 0, rsp_valid 0, cmd_ready 1.
- FSM states: IDLE, MEM_ACC, REG_ACC, REG_HOLD, RUN_RST, RUN_EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch op/addr/data and drop cmd_ready the next cycle.
  - NOP and illegal ops go straight to RESP; illegal sets rsp_err=1.
- MEM_ACC (WMEM/RMEM):
  - memoryoperation=1 and memaddress=addr; memorywrite=1 for WMEM only; memwritedata=data.
  - Held for MEM_ACC_CYC cycles, then MD is sampled.
  - WMEM: err = (MD != data). rsp_data = MD.
  - memorywrite and memoryoperation drop in the same cycle, then go to RESP.
- REG_ACC (WREG/RREG):
  - registeroperation=1 and registeraddress=addr[3:0]; registerwrite=1 for WREG; regwritedata=data.
  - Held REG_ACC_CYC cycles, then RD is sampled; WREG err = (RD != data).
  - REG_HOLD: controls held one more cycle, then registerwrite and registeroperation drop together. Go to RESP.
- RUN:
  - RUN_RST: one cycle with cpu_reset=1, resetpc=addr, test=0.
  - RUN_EXEC: test=1.
  - Count rising entries into state==FETCH_STATE, using edge detect against the previous-cycle state.
  - Target = data+1 fetches, computed in 17 bits so data=FFFF does not wrap. The final fetch ends execution before that instruction runs.
  - On reaching target: test=0, rsp_data=data, err=0.
  - Cycle counter reaches RUN_TIMEOUT first: test=0, rsp_data = fetches-1 (saturating at 0), err=1.
  - data=0: returns after the first fetch, with zero instructions executed.
- Mutual exclusion: test is never 1 in a cycle where memoryoperation or registeroperation is 1. cpu_reset is never 1 outside RUN_RST.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_data/rsp_err hold until the next response.
- cmd_valid while busy is ignored; no queueing. Host must wait for cmd_ready.
- Reset mid-operation: all debug controls drop in the cycle after the reset edge, and no response is issued.

Decomposition:
- Package debug_host_pkg: cmd_op encodings, FSM state enum, FETCH_STATE default.
- One sub-module: fetch_counter. It holds the edge detect on state, the 17-bit fetch count, the timeout counter, and done/timeout flags.

Test Plan:
- WMEM addr 0x000A data 0x612F -> memoryoperation high 2 cycles, memorywrite high, rsp_valid pulse, rsp_data=0x612F, rsp_err=0.
- WREG addr 2 data 0x0112, then RREG addr 2 -> registeroperation high 3 cycles on write; read rsp_data=0x0112, err=0.
- Program sequence:
  - Commands: WMEM 10=0x612F, WREG 2=0x0112, WMEM 0x0112=12, RUN addr 10 data 1, RREG 1.
  - Response: cpu_reset pulses once with resetpc=10; RUN rsp_data=1; RREG rsp_data=12.
- RUN with PC pointing at a self-loop jump, data=0xFFFF, RUN_TIMEOUT=64 -> test drops after 64 cycles, rsp_err=1.
- cmd_op=7 -> rsp_err=1, no debug control toggles. cmd_valid asserted during a RUN -> ignored, cmd_ready=0.
- Assert reset during MEM_ACC of a WMEM -> memorywrite/memoryoperation 0 on the next cycle, no rsp_valid, cmd_ready=1.

Source files
------------

// File: rtl/debug_host_pkg.sv
// Shared encodings for the SystemTest debug host sequencer: host opcodes,
// sequencer FSM states and defaults describing the target CPU.
package debug_host_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_WMEM = 3'd1,
    OP_WREG = 3'd2,
    OP_RMEM = 3'd3,
    OP_RREG = 3'd4,
    OP_RUN  = 3'd5
  } cmd_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_ACC,
    S_REG_ACC,
    S_REG_HOLD,
    S_RUN_RST,
    S_RUN_EXEC,
    S_RESP
  } fsm_state_e;

  localparam logic [8:0]  FETCH_STATE_DEF = 9'd1;
  localparam logic [15:0] RUN_TIMEOUT_DEF = 16'd4096;

  // Instructions actually executed when a run stops at a given fetch count.
  function automatic logic [15:0] executed_from_fetches(input logic [16:0] fetches);
    logic [16:0] dec;
    dec = fetches - 17'd1;
    return (fetches == '0) ? '0 : dec[15:0];
  endfunction

endpackage

// File: rtl/debug_host_sequencer_fetch_counter.sv
// Run-phase bookkeeping: rising-edge detect on the CPU fetch state, fetch count
// against a 17-bit target, and an execution-cycle timeout.
module fetch_counter
  import debug_host_pkg::*;
#(
  parameter logic [15:0] RUN_TIMEOUT = RUN_TIMEOUT_DEF,
  parameter logic [8:0]  FETCH_STATE = FETCH_STATE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        en,
  input  logic [8:0]  state,
  input  logic [16:0] target,
  output logic [16:0] fetches,
  output logic        done,
  output logic        timeout
);

  logic        prev_fetch;
  logic        rise;
  logic [16:0] fetch_q;
  logic [15:0] cyc_q;

  // Flags include the current cycle's fetch so execution stops before that instruction runs.
  always_comb begin
    rise    = en && (state == FETCH_STATE) && !prev_fetch;
    fetches = fetch_q + {16'd0, rise};
    done    = rise && (fetches == target);
    timeout = en && (cyc_q == (RUN_TIMEOUT - 16'd1));
  end

  always_ff @(posedge clk) begin
    if (!reset || start) begin
      prev_fetch <= 1'b0;
      fetch_q    <= '0;
      cyc_q      <= '0;
    end else begin
      prev_fetch <= (state == FETCH_STATE);
      if (en) begin
        fetch_q <= fetches;
        cyc_q   <= cyc_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/debug_host_sequencer.sv
// Host command engine for the SystemTest debug port: turns memory/register
// accesses and RUN requests into debug-control cycle sequences, one response each.
module debug_host_sequencer
  import debug_host_pkg::*;
#(
  parameter int unsigned MEM_ACC_CYC = 2,
  parameter int unsigned REG_ACC_CYC = 2,
  parameter logic [15:0] RUN_TIMEOUT = RUN_TIMEOUT_DEF,
  parameter logic [8:0]  FETCH_STATE = FETCH_STATE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        cpu_reset,
  output logic        test,
  output logic        memoryoperation,
  output logic        registeroperation,
  output logic        memorywrite,
  output logic        registerwrite,
  output logic [15:0] memaddress,
  output logic [15:0] memwritedata,
  output logic [15:0] regwritedata,
  output logic [15:0] resetpc,
  output logic [3:0]  registeraddress,
  input  logic [15:0] MD,
  input  logic [15:0] RD,
  input  logic [8:0]  state
);

  fsm_state_e  fsm;
  cmd_op_e     op_q;
  logic [15:0] data_q;
  logic [7:0]  acc_cnt;
  logic [15:0] rd_q;
  logic        err_q;
  logic [16:0] fetch_cnt;
  logic        run_done;
  logic        run_timeout;

  fetch_counter #(
    .RUN_TIMEOUT(RUN_TIMEOUT),
    .FETCH_STATE(FETCH_STATE)
  ) u_fetch_counter (
    .clk     (clk),
    .reset   (reset),
    .start   (fsm == S_RUN_RST),
    .en      (fsm == S_RUN_EXEC),
    .state   (state),
    .target  ({1'b0, data_q} + 17'd1),
    .fetches (fetch_cnt),
    .done    (run_done),
    .timeout (run_timeout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm               <= S_IDLE;
      op_q              <= OP_NOP;
      data_q            <= '0;
      acc_cnt           <= '0;
      rd_q              <= '0;
      err_q             <= 1'b0;
      cmd_ready         <= 1'b1;
      rsp_valid         <= 1'b0;
      rsp_data          <= '0;
      rsp_err           <= 1'b0;
      cpu_reset         <= 1'b0;
      test              <= 1'b0;
      memoryoperation   <= 1'b0;
      registeroperation <= 1'b0;
      memorywrite       <= 1'b0;
      registerwrite     <= 1'b0;
      memaddress        <= '0;
      memwritedata      <= '0;
      regwritedata      <= '0;
      resetpc           <= '0;
      registeraddress   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (fsm)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op_e'(cmd_op);
            data_q    <= cmd_data;
            acc_cnt   <= '0;
            cmd_ready <= 1'b0;
            case (cmd_op_e'(cmd_op))
              OP_WMEM, OP_RMEM: begin
                fsm             <= S_MEM_ACC;
                memoryoperation <= 1'b1;
                memorywrite     <= (cmd_op_e'(cmd_op) == OP_WMEM);
                memaddress      <= cmd_addr;
                memwritedata    <= cmd_data;
              end
              OP_WREG, OP_RREG: begin
                fsm               <= S_REG_ACC;
                registeroperation <= 1'b1;
                registerwrite     <= (cmd_op_e'(cmd_op) == OP_WREG);
                registeraddress   <= cmd_addr[3:0];
                regwritedata      <= cmd_data;
              end
              OP_RUN: begin
                fsm       <= S_RUN_RST;
                cpu_reset <= 1'b1;
                resetpc   <= cmd_addr;
                test      <= 1'b0;
              end
              OP_NOP: begin
                fsm       <= S_RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_err   <= 1'b0;
              end
              default: begin
                fsm       <= S_RESP;
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
              end
            endcase
          end
        end

        S_MEM_ACC: begin
          if (acc_cnt == 8'(MEM_ACC_CYC - 1)) begin
            memoryoperation <= 1'b0;
            memorywrite     <= 1'b0;
            rsp_data        <= MD;
            rsp_err         <= (op_q == OP_WMEM) && (MD != data_q);
            rsp_valid       <= 1'b1;
            fsm             <= S_RESP;
          end else begin
            acc_cnt <= acc_cnt + 8'd1;
          end
        end

        // Readback is parked in rd_q/err_q so the previous response stays stable through the hold cycle.
        S_REG_ACC: begin
          if (acc_cnt == 8'(REG_ACC_CYC - 1)) begin
            rd_q  <= RD;
            err_q <= (op_q == OP_WREG) && (RD != data_q);
            fsm   <= S_REG_HOLD;
          end else begin
            acc_cnt <= acc_cnt + 8'd1;
          end
        end

        S_REG_HOLD: begin
          registeroperation <= 1'b0;
          registerwrite     <= 1'b0;
          rsp_data          <= rd_q;
          rsp_err           <= err_q;
          rsp_valid         <= 1'b1;
          fsm               <= S_RESP;
        end

        S_RUN_RST: begin
          cpu_reset <= 1'b0;
          test      <= 1'b1;
          fsm       <= S_RUN_EXEC;
        end

        S_RUN_EXEC: begin
          if (run_done) begin
            test      <= 1'b0;
            rsp_data  <= data_q;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            fsm       <= S_RESP;
          end else if (run_timeout) begin
            test      <= 1'b0;
            rsp_data  <= executed_from_fetches(fetch_cnt);
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            fsm       <= S_RESP;
          end
        end

        S_RESP: begin
          cmd_ready <= 1'b1;
          fsm       <= S_IDLE;
        end

        default: begin
          cmd_ready <= 1'b1;
          fsm       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_host_sequencer.sv
// Directed plus randomized bench for debug_host_sequencer, with a small SystemTest
// CPU/memory environment and a high-level expectation model of each command.
module tb_debug_host_sequencer;
  import debug_host_pkg::*;

  localparam logic [8:0] FETCH = 9'd1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr, cmd_data;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_data;
  logic        cpu_reset, test, memoryoperation, registeroperation, memorywrite, registerwrite;
  logic [15:0] memaddress, memwritedata, regwritedata, resetpc;
  logic [3:0]  registeraddress;
  logic [15:0] MD, RD;
  logic [8:0]  state;

  always #5 clk = ~clk;

  debug_host_sequencer #(
    .MEM_ACC_CYC(2),
    .REG_ACC_CYC(2),
    .RUN_TIMEOUT(16'd64),
    .FETCH_STATE(FETCH)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cpu_reset(cpu_reset), .test(test),
    .memoryoperation(memoryoperation), .registeroperation(registeroperation),
    .memorywrite(memorywrite), .registerwrite(registerwrite),
    .memaddress(memaddress), .memwritedata(memwritedata),
    .regwritedata(regwritedata), .resetpc(resetpc),
    .registeraddress(registeraddress),
    .MD(MD), .RD(RD), .state(state)
  );

  // SystemTest stand-in: memory (0x3FF is a stuck cell), register file, and a
  // fetch/execute CPU. Opcode 6: R[a] = mem[R[b]]; opcode F: jump; others: no-op.
  logic [15:0] mem   [0:1023] = '{default: 16'h0000};
  logic [15:0] cregs [0:15]   = '{default: 16'h0000};
  logic [8:0]  cst = 9'd0;
  logic [15:0] pc = 16'h0000, ir = 16'h0000;
  int unsigned exec_left = 0;
  int          n_exec = 0;

  assign MD    = (memaddress[9:0] == 10'h3FF) ? 16'hDEAD : mem[memaddress[9:0]];
  assign RD    = cregs[registeraddress];
  assign state = cst;

  always @(posedge clk) begin
    if (memoryoperation && memorywrite) mem[memaddress[9:0]] <= memwritedata;
    if (registeroperation && registerwrite) cregs[registeraddress] <= regwritedata;
    if (cpu_reset) begin
      cst <= 9'd0;
      pc  <= resetpc;
    end else if (test) begin
      case (cst)
        9'd0: cst <= FETCH;
        FETCH: begin
          ir        <= mem[pc[9:0]];
          exec_left <= $urandom_range(0, 2);
          cst       <= 9'd2;
        end
        default: begin
          if (exec_left != 0) begin
            exec_left <= exec_left - 1;
          end else begin
            case (ir[15:12])
              4'h6: begin
                cregs[ir[11:8]] <= mem[cregs[ir[7:4]][9:0]];
                pc <= pc + 16'd1;
              end
              4'hF: pc <= {4'h0, ir[11:0]};
              default: pc <= pc + 16'd1;
            endcase
            n_exec <= n_exec + 1;
            cst    <= FETCH;
          end
        end
      endcase
    end
  end

  // Activity monitor, sampled away from the active edge.
  int n_memop = 0, n_memwr = 0, n_regop = 0, n_regwr = 0, n_test = 0;
  int n_cpurst = 0, n_fetch = 0, n_rsp = 0, n_excl = 0;
  logic [15:0] last_resetpc = 16'h0000;
  logic [8:0]  prev_st = 9'd0;

  always @(negedge clk) begin
    if (memoryoperation)   n_memop++;
    if (memorywrite)       n_memwr++;
    if (registeroperation) n_regop++;
    if (registerwrite)     n_regwr++;
    if (test)              n_test++;
    if (rsp_valid)         n_rsp++;
    if (cpu_reset) begin
      n_cpurst++;
      last_resetpc = resetpc;
    end
    if (test && (memoryoperation || registeroperation)) n_excl++;
    if (test && cpu_reset) n_excl++;
    if (test && state == FETCH && prev_st != FETCH) n_fetch++;
    prev_st = state;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-command activity deltas.
  int d_memop, d_memwr, d_regop, d_regwr, d_test, d_cpurst, d_fetch, d_exec, d_rsp, d_excl;

  task automatic do_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] d,
                        input bit poke, output logic [15:0] rd, output logic re);
    int unsigned t;
    int s_memop, s_memwr, s_regop, s_regwr, s_test, s_cpurst, s_fetch, s_exec, s_rsp, s_excl;
    @(negedge clk);
    t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", 32'(t < 100), 32'd1);
    #1;
    s_memop = n_memop; s_memwr = n_memwr; s_regop = n_regop; s_regwr = n_regwr;
    s_test = n_test; s_cpurst = n_cpurst; s_fetch = n_fetch; s_exec = n_exec;
    s_rsp = n_rsp; s_excl = n_excl;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    chk("ready_drop", 32'(cmd_ready), 32'd0);
    if (poke) begin
      cmd_op = OP_WMEM; cmd_addr = 16'h0050; cmd_data = 16'hBAD0;
    end else begin
      cmd_valid = 1'b0;
    end
    t = 0;
    while (rsp_valid !== 1'b1 && t < 400) begin
      if (poke) chk("busy_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      t++;
    end
    cmd_valid = 1'b0;
    chk("rsp_wait", 32'(t < 400), 32'd1);
    rd = rsp_data;
    re = rsp_err;
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    #1;
    d_memop = n_memop - s_memop; d_memwr = n_memwr - s_memwr;
    d_regop = n_regop - s_regop; d_regwr = n_regwr - s_regwr;
    d_test = n_test - s_test; d_cpurst = n_cpurst - s_cpurst;
    d_fetch = n_fetch - s_fetch; d_exec = n_exec - s_exec;
    d_rsp = n_rsp - s_rsp; d_excl = n_excl - s_excl;
    chk("one_rsp", 32'(d_rsp), 32'd1);
  endtask

  // Expectation model: what each memory location and register should hold.
  logic [15:0] ref_mem [int unsigned];
  logic [15:0] ref_reg [0:15] = '{default: 16'h0000};

  function automatic logic [15:0] exp_mem(input logic [15:0] a);
    if (a[9:0] == 10'h3FF) return 16'hDEAD;
    return ref_mem.exists(32'(a)) ? ref_mem[32'(a)] : 16'h0000;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rd, a, d;
    logic        re;
    int unsigned k, n, s_rsp;
    int          f;

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_controls", 32'({cpu_reset, test, memoryoperation, registeroperation,
                             memorywrite, registerwrite}), 32'd0);
    chk("rst_buses", 32'(|{memaddress, memwritedata, regwritedata, resetpc, registeraddress}), 32'd0);
    reset = 1'b1;

    // Directed memory/register accesses and the small program.
    do_cmd(OP_WMEM, 16'h000A, 16'h612F, 1'b0, rd, re);
    chk("wmem_data", 32'(rd), 32'h612F);
    chk("wmem_err", 32'(re), 32'd0);
    chk("wmem_memop_cyc", 32'(d_memop), 32'd2);
    chk("wmem_memwr_cyc", 32'(d_memwr), 32'd2);
    chk("wmem_no_reg_test", 32'(d_regop + d_test + d_cpurst), 32'd0);
    ref_mem[32'h000A] = 16'h612F;

    do_cmd(OP_WREG, 16'h0002, 16'h0112, 1'b0, rd, re);
    chk("wreg_data", 32'(rd), 32'h0112);
    chk("wreg_err", 32'(re), 32'd0);
    chk("wreg_regop_cyc", 32'(d_regop), 32'd3);
    chk("wreg_regwr_cyc", 32'(d_regwr), 32'd3);
    ref_reg[2] = 16'h0112;

    do_cmd(OP_RREG, 16'h0002, 16'h0000, 1'b0, rd, re);
    chk("rreg_data", 32'(rd), 32'(ref_reg[2]));
    chk("rreg_err", 32'(re), 32'd0);
    chk("rreg_no_write", 32'(d_regwr), 32'd0);

    do_cmd(OP_WMEM, 16'h0112, 16'd12, 1'b0, rd, re);
    chk("wmem2_err", 32'(re), 32'd0);
    ref_mem[32'h0112] = 16'd12;

    do_cmd(OP_RUN, 16'd10, 16'd1, 1'b0, rd, re);
    chk("prog_run_data", 32'(rd), 32'd1);
    chk("prog_run_err", 32'(re), 32'd0);
    chk("prog_cpurst_cyc", 32'(d_cpurst), 32'd1);
    chk("prog_resetpc", 32'(last_resetpc), 32'd10);
    chk("prog_executed", 32'(d_exec), 32'd1);
    ref_reg[1] = ref_mem[32'h0112];

    do_cmd(OP_RREG, 16'h0001, 16'h0000, 1'b0, rd, re);
    chk("prog_rreg1", 32'(rd), 32'(ref_reg[1]));

    // Randomized memory and register traffic.
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 3);
      d = 16'($urandom);
      case (k)
        0: begin
          a = 16'($urandom_range(32, 255));
          do_cmd(OP_WMEM, a, d, 1'b0, rd, re);
          chk("rnd_wmem_data", 32'(rd), 32'(d));
          chk("rnd_wmem_err", 32'(re), 32'd0);
          ref_mem[32'(a)] = d;
        end
        1: begin
          a = 16'($urandom_range(10, 255));
          do_cmd(OP_RMEM, a, 16'h0000, 1'b0, rd, re);
          chk("rnd_rmem_data", 32'(rd), 32'(exp_mem(a)));
          chk("rnd_rmem_err", 32'(re), 32'd0);
          chk("rnd_rmem_nowr", 32'(d_memwr), 32'd0);
        end
        2: begin
          a = 16'($urandom_range(0, 15));
          do_cmd(OP_WREG, a, d, 1'b0, rd, re);
          chk("rnd_wreg_data", 32'(rd), 32'(d));
          chk("rnd_wreg_err", 32'(re), 32'd0);
          ref_reg[a[3:0]] = d;
        end
        default: begin
          a = 16'($urandom_range(0, 15));
          do_cmd(OP_RREG, a, 16'h0000, 1'b0, rd, re);
          chk("rnd_rreg_data", 32'(rd), 32'(ref_reg[a[3:0]]));
          chk("rnd_rreg_err", 32'(re), 32'd0);
        end
      endcase
    end

    // RUNs over a no-op region, first with zero instructions.
    for (int i = 0; i < 6; i++) begin
      n = (i == 0) ? 0 : $urandom_range(1, 8);
      a = 16'h0300 + 16'($urandom_range(0, 15));
      do_cmd(OP_RUN, a, 16'(n), 1'b0, rd, re);
      chk("run_data", 32'(rd), n);
      chk("run_err", 32'(re), 32'd0);
      chk("run_executed", 32'(d_exec), n);
      chk("run_fetches", 32'(d_fetch), n + 1);
      chk("run_cpurst_cyc", 32'(d_cpurst), 32'd1);
      chk("run_resetpc", 32'(last_resetpc), 32'(a));
      chk("run_excl", 32'(d_excl), 32'd0);
    end

    // Self-loop jump with an unreachable count: must time out after 64 cycles.
    do_cmd(OP_WMEM, 16'h03F8, 16'hF3F8, 1'b0, rd, re);
    chk("loop_wmem_err", 32'(re), 32'd0);
    ref_mem[32'h03F8] = 16'hF3F8;
    do_cmd(OP_RUN, 16'h03F8, 16'hFFFF, 1'b0, rd, re);
    f = (d_fetch == 0) ? 0 : d_fetch - 1;
    chk("tmo_err", 32'(re), 32'd1);
    chk("tmo_test_cyc", 32'(d_test), 32'd64);
    chk("tmo_data", 32'(rd), 32'(f));
    chk("tmo_excl", 32'(d_excl), 32'd0);

    // Illegal ops and NOP: response only, no debug activity.
    do_cmd(3'd7, 16'h1234, 16'h5678, 1'b0, rd, re);
    chk("ill7_err", 32'(re), 32'd1);
    chk("ill7_quiet", 32'(d_memop + d_regop + d_test + d_cpurst), 32'd0);
    do_cmd(3'd6, 16'h0001, 16'h0001, 1'b0, rd, re);
    chk("ill6_err", 32'(re), 32'd1);
    chk("ill6_quiet", 32'(d_memop + d_regop + d_test + d_cpurst), 32'd0);
    do_cmd(OP_NOP, 16'h0000, 16'h0000, 1'b0, rd, re);
    chk("nop_err", 32'(re), 32'd0);
    chk("nop_quiet", 32'(d_memop + d_regop + d_test + d_cpurst), 32'd0);

    // Host keeps cmd_valid up with a WMEM during a RUN: must be ignored.
    do_cmd(OP_RUN, 16'h0305, 16'd6, 1'b1, rd, re);
    chk("busy_run_data", 32'(rd), 32'd6);
    chk("busy_no_memop", 32'(d_memop), 32'd0);
    do_cmd(OP_RMEM, 16'h0050, 16'h0000, 1'b0, rd, re);
    chk("busy_mem_untouched", 32'(rd), 32'(exp_mem(16'h0050)));

    // Write to the stuck cell reports a readback mismatch.
    do_cmd(OP_WMEM, 16'h03FF, 16'h1234, 1'b0, rd, re);
    chk("stuck_err", 32'(re), 32'd1);
    chk("stuck_data", 32'(rd), 32'hDEAD);

    // Reset in the middle of a WMEM access.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_WMEM; cmd_addr = 16'h0040; cmd_data = 16'h5555;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mid_memop_on", 32'(memoryoperation), 32'd1);
    #1;
    s_rsp = 32'(n_rsp);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_memop_off", 32'(memoryoperation), 32'd0);
    chk("mid_memwr_off", 32'(memorywrite), 32'd0);
    chk("mid_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("mid_no_rsp", 32'(n_rsp) - s_rsp, 32'd0);
    chk("global_excl", 32'(n_excl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
